// File: rtl/key_debounce.sv
// key_debounce: three independent push-button debouncers.
// Each raw key is synchronized with two flops. A per-key state machine then
// requires CNT_MAX consecutive stable samples before it changes the debounced
// level. A one-cycle key_press pulse is emitted on every accepted press.
// Optional feature (macro KEY_REPEAT_EN): key2 auto-repeats while held. After
// REPEAT_DELAY cycles in HELD its level dips for one cycle and a fresh pulse
// follows. Further dips follow every REPEAT_PERIOD cycles.
// Without KEY_REPEAT_EN no repeat logic is built.

module key_debounce #(
    parameter int CNT_MAX       = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_raw,
    output logic       key1_in,
    output logic       key2_in,
    output logic       key3_in,
    output logic [2:0] key_press
);

    // Counter must hold the largest of the three timing parameters.
    localparam int MAX_AB   = (CNT_MAX > REPEAT_DELAY) ? CNT_MAX : REPEAT_DELAY;
    localparam int MAX_ALL  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W    = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // The IDLE/HELD cycle that first sees the new level is itself one stable
    // sample. The wait state therefore needs CNT_MAX-1 more samples, which
    // ends when the counter would step onto CNT_MAX-1.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((CNT_MAX >= 2) ? CNT_MAX - 2 : 0);

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } keyState_e;

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] keyLow;

    // Saturating increment so a long stable level can never wrap the count.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == CNT_SAT) ? value : value + 1'b1;
    endfunction

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign keyLow = ~sync2_q;

    for (genvar k = 0; k < 3; k++) begin : gKey
        keyState_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             pulse_q;
`ifdef KEY_REPEAT_EN
        localparam bit IS_REPEAT_KEY = (k == 1);
        logic          repeatDone_q;
`endif

        // Per-key debounce FSM with registered level and press pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= IDLE;
                cnt_q        <= '0;
                level_q      <= 1'b0;
                pulse_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
                repeatDone_q <= 1'b0;
`endif
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (keyLow[k]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!keyLow[k]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == WAIT_LAST) begin
                            state_q      <= HELD;
                            cnt_q        <= '0;
                            level_q      <= 1'b1;
                            pulse_q      <= 1'b1;
`ifdef KEY_REPEAT_EN
                            repeatDone_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= satInc(cnt_q);
                        end
                    end
                    HELD: begin
                        if (!keyLow[k]) begin
                            state_q      <= RELEASE_WAIT;
                            cnt_q        <= '0;
`ifdef KEY_REPEAT_EN
                            repeatDone_q <= 1'b0;
                        end else if (IS_REPEAT_KEY) begin
                            if (!level_q) begin
                                level_q <= 1'b1;
                                pulse_q <= 1'b1;
                                cnt_q   <= satInc(cnt_q);
                            end else if (cnt_q == (repeatDone_q ? PERIOD_LAST : DELAY_LAST)) begin
                                level_q      <= 1'b0;
                                cnt_q        <= '0;
                                repeatDone_q <= 1'b1;
                            end else begin
                                cnt_q <= satInc(cnt_q);
                            end
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        if (keyLow[k]) begin
                            state_q      <= HELD;
                            cnt_q        <= '0;
`ifdef KEY_REPEAT_EN
                            repeatDone_q <= 1'b0;
`endif
                        end else if (cnt_q == WAIT_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= satInc(cnt_q);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key1_in   = gKey[0].level_q;
    assign key2_in   = gKey[1].level_q;
    assign key3_in   = gKey[2].level_q;
    assign key_press = {gKey[2].pulse_q, gKey[1].pulse_q, gKey[0].pulse_q};

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce.
// Uses CNT_MAX=8, REPEAT_DELAY=40 and REPEAT_PERIOD=16. A press on key_raw
// shows up on the outputs 10 clock edges after the raw input changes.

module tb_key_debounce;

    localparam int CNT_MAX       = 8;
    localparam int REPEAT_DELAY  = 40;
    localparam int REPEAT_PERIOD = 16;

    logic       clk;
    logic       rst_n;
    logic [2:0] key_raw;
    logic       key1_in;
    logic       key2_in;
    logic       key3_in;
    logic [2:0] key_press;
    logic [2:0] levels;

    int checkCount;
    int errorCount;
    int pressCount [3];

    key_debounce #(
        .CNT_MAX      (CNT_MAX),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (key_raw),
        .key1_in  (key1_in),
        .key2_in  (key2_in),
        .key3_in  (key3_in),
        .key_press(key_press)
    );

    assign levels = {key3_in, key2_in, key1_in};

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count pulses per key, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (key_press[i]) pressCount[i] = pressCount[i] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] value, input int n);
        key_raw = value;
        tick(n);
    endtask

    int base0;
    int base1;
    int base2;
    logic expLevel;

    initial begin
        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 3; i++) pressCount[i] = 0;
        key_raw = 3'b111;
        rst_n   = 1'b0;

        // Reset state
        tick(3);
        checkOutput("reset_levels", 32'(levels), 32'h0);
        checkOutput("reset_press", 32'(key_press), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Clean press of key1
        base0 = pressCount[0];
        applyStimulus(3'b110, 9);
        checkOutput("clean_before", 32'(levels), 32'h0);
        tick(1);
        checkOutput("clean_level", 32'(levels), 32'h1);
        checkOutput("clean_pulse", 32'(key_press), 32'h1);
        tick(1);
        checkOutput("clean_pulse_end", 32'(key_press), 32'h0);
        checkOutput("clean_held", 32'(levels), 32'h1);
        applyStimulus(3'b111, 9);
        checkOutput("clean_rel_before", 32'(levels), 32'h1);
        tick(1);
        checkOutput("clean_released", 32'(levels), 32'h0);
        checkOutput("clean_no_rel_pulse", 32'(pressCount[0] - base0), 32'd1);
        tick(3);

        // Bounce on key2
        base1 = pressCount[1];
        applyStimulus(3'b101, 5);
        applyStimulus(3'b111, 1);
        applyStimulus(3'b101, 9);
        checkOutput("bounce_before", 32'(levels), 32'h0);
        checkOutput("bounce_no_pulse", 32'(pressCount[1] - base1), 32'd0);
        tick(1);
        checkOutput("bounce_level", 32'(levels), 32'h2);
        checkOutput("bounce_pulse", 32'(key_press), 32'h2);
        applyStimulus(3'b111, 10);
        checkOutput("bounce_released", 32'(levels), 32'h0);
        checkOutput("bounce_one_pulse", 32'(pressCount[1] - base1), 32'd1);
        tick(3);

        // Simultaneous key1 + key3
        base0 = pressCount[0];
        base2 = pressCount[2];
        applyStimulus(3'b010, 9);
        checkOutput("simul_before", 32'(levels), 32'h0);
        tick(1);
        checkOutput("simul_level", 32'(levels), 32'h5);
        checkOutput("simul_pulse", 32'(key_press), 32'h5);
        applyStimulus(3'b111, 10);
        checkOutput("simul_released", 32'(levels), 32'h0);
        checkOutput("simul_cnt1", 32'(pressCount[0] - base0), 32'd1);
        checkOutput("simul_cnt3", 32'(pressCount[2] - base2), 32'd1);
        tick(3);

        // Release glitch on key1 while held
        base0 = pressCount[0];
        applyStimulus(3'b110, 10);
        checkOutput("glitch_pressed", 32'(levels), 32'h1);
        applyStimulus(3'b111, 3);
        checkOutput("glitch_mid", 32'(levels), 32'h1);
        applyStimulus(3'b110, 12);
        checkOutput("glitch_after", 32'(levels), 32'h1);
        checkOutput("glitch_no_pulse", 32'(pressCount[0] - base0), 32'd1);
        applyStimulus(3'b111, 9);
        checkOutput("glitch_rel_before", 32'(levels), 32'h1);
        tick(1);
        checkOutput("glitch_released", 32'(levels), 32'h0);
        tick(3);

        // Reset in the middle of a press debounce
        base0 = pressCount[0];
        applyStimulus(3'b110, 6);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_levels", 32'(levels), 32'h0);
        checkOutput("rstmid_press", 32'(key_press), 32'h0);
        tick(2);
        rst_n = 1'b1;
        applyStimulus(3'b110, 9);
        checkOutput("rstmid_before", 32'(levels), 32'h0);
        checkOutput("rstmid_no_pulse", 32'(pressCount[0] - base0), 32'd0);
        tick(1);
        checkOutput("rstmid_level", 32'(levels), 32'h1);
        checkOutput("rstmid_pulse", 32'(key_press), 32'h1);
        applyStimulus(3'b111, 10);
        checkOutput("rstmid_released", 32'(levels), 32'h0);
        checkOutput("rstmid_one_pulse", 32'(pressCount[0] - base0), 32'd1);
        tick(3);

        // Long hold on key2 (auto-repeat only in the repeat build)
        base1 = pressCount[1];
        applyStimulus(3'b101, 10);
        checkOutput("hold_level", 32'(levels), 32'h2);
        checkOutput("hold_pulse", 32'(key_press), 32'h2);
        for (int k = 1; k <= 100; k++) begin
            tick(1);
`ifdef KEY_REPEAT_EN
            expLevel = !(k == 40 || k == 56 || k == 72 || k == 88);
`else
            expLevel = 1'b1;
`endif
            checkOutput($sformatf("hold_k%0d", k), 32'(key2_in), 32'(expLevel));
        end
`ifdef KEY_REPEAT_EN
        checkOutput("hold_pulses", 32'(pressCount[1] - base1), 32'd5);
`else
        checkOutput("hold_pulses", 32'(pressCount[1] - base1), 32'd1);
`endif
        applyStimulus(3'b111, 9);
        checkOutput("hold_rel_before", 32'(levels), 32'h2);
        tick(1);
        checkOutput("hold_released", 32'(levels), 32'h0);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 1000000, meaning stable-time cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles before auto-repeat starts (macro build only).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between auto-repeat edges (macro build only).
REQ-004 The block SHALL have port clk, input, 1, meaning system clock.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset.
REQ-006 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-007 The block SHALL have port key_raw, input, 3, meaning raw push-buttons [0]=key1, [1]=key2, [2]=key3; active-low and asynchronous to clk.
REQ-008 The block SHALL have port key1_in, output, 1, meaning debounced key1 level, 1=pressed.
REQ-009 The block SHALL have port key2_in, output, 1, meaning debounced key2 level, 1=pressed.
REQ-010 The block SHALL have port key3_in, output, 1, meaning debounced key3 level, 1=pressed.
REQ-011 The block SHALL have port key_press, output, 3, meaning one-cycle pulse per key on each accepted press.

Function
REQ-012 Each key_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each key SHALL run an independent state machine with states IDLE (released), PRESS_WAIT, HELD, and RELEASE_WAIT.
REQ-014 In IDLE, a synchronized low SHALL move the key to PRESS_WAIT and clear its counter.
REQ-015 In PRESS_WAIT, the counter SHALL increment while the input stays low; any high SHALL return the key to IDLE with the counter cleared.
REQ-016 When the PRESS_WAIT counter reaches CNT_MAX-1, the key SHALL enter HELD, set its keyN_in to 1 on the same edge, and pulse key_press[N] for exactly one cycle.
REQ-017 In HELD, a synchronized high SHALL move the key to RELEASE_WAIT and clear its counter.
REQ-018 In RELEASE_WAIT, the counter SHALL increment while the input stays high; any low SHALL return the key to HELD with no output change.
REQ-019 When the RELEASE_WAIT counter reaches CNT_MAX-1, the key SHALL enter IDLE and clear keyN_in; no pulse is generated on release.
REQ-020 Press-to-output latency SHALL be 2 synchronizer cycles plus CNT_MAX cycles of stable low.
REQ-021 Each counter SHALL be sized to hold the largest parameter and SHALL saturate, never wrap.
REQ-022 Keys SHALL be fully independent; simultaneous presses (for example key1 and key3 together) SHALL each produce their own level and pulse on their own qualifying cycle, with no priority or masking.
REQ-023 Glitches shorter than CNT_MAX cycles SHALL never change any output.

Reset
REQ-024 While rst_n is 0, all synchronizer flops SHALL be 1 (released), all FSMs SHALL be in IDLE, all counters SHALL be 0, and key1_in, key2_in, key3_in and key_press SHALL all be 0.
REQ-025 Assertion of rst_n mid-debounce or mid-hold SHALL abort immediately with no output pulse.
REQ-026 A key held through reset release SHALL be re-debounced from IDLE and then reported as a fresh press.

Configuration
REQ-027 The block SHALL support macro KEY_REPEAT_EN.
REQ-028 With KEY_REPEAT_EN defined, key2 held in HELD for REPEAT_DELAY cycles SHALL drive key2_in to 0 for exactly one cycle and then back to 1, pulsing key_press[1] on the return-to-1 cycle.
REQ-029 With KEY_REPEAT_EN defined, after the first repeat, further repeats SHALL occur every REPEAT_PERIOD cycles until release, producing a fresh rising edge for the downstream increment logic on each repeat.
REQ-030 With KEY_REPEAT_EN defined, a release entering RELEASE_WAIT SHALL cancel repeat timing.
REQ-031 Without KEY_REPEAT_EN, no repeat logic SHALL exist and key2 SHALL behave as key1 and key3; key1 and key3 SHALL never repeat in either build.

Verification (CNT_MAX=8, REPEAT_DELAY=40, REPEAT_PERIOD=16)
REQ-032 Clean press: key_raw[0] driven low and held -> key1_in rises 10 cycles later, with key_press=3'b001 for that single cycle.
REQ-033 Bounce: key_raw[1] toggles low 5 cycles, high 1, low and held -> no output before the final low plus 10 cycles; exactly one pulse.
REQ-034 Simultaneous press: key_raw[0] and key_raw[2] driven low on the same cycle -> key1_in and key3_in rise on the same cycle and key_press=3'b101.
REQ-035 Release glitch: while HELD, key_raw[0] goes high 3 cycles then low -> key1_in stays 1 throughout; after a real release plus 10 cycles, key1_in falls.
REQ-036 Reset mid-debounce: rst_n asserted 4 cycles into PRESS_WAIT -> all outputs 0; with the key still low after rst_n release, the press is reported 10 cycles later.
REQ-037 With KEY_REPEAT_EN: key2 held for 100 cycles after HELD -> key2_in low for one cycle at HELD+40, +56, +72, +88, and key_press[1] pulses 5 times in total.
